// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM pipeline register with valid bit, flush/stall handling and a circular store history
// with word-address lookup for store-to-load forwarding. Optional macro: SB_BYPASS_EN.

`ifndef MEM_NOP_OP
`define MEM_NOP_OP 4'h0
`endif
`ifndef MEM_SW_OP
`define MEM_SW_OP 4'h2
`endif

module exe_mem_pipe_reg #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MOP_W    = 4,
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        exe_valid,
  input  logic [XLEN-1:0]             exe_pc,
  input  logic                        exe_we,
  input  logic [REG_AW-1:0]           exe_write_reg,
  input  logic [XLEN-1:0]             exe_write_data,
  input  logic [MOP_W-1:0]            exe_mem_op,
  input  logic [XLEN-1:0]             exe_mem_addr,
  input  logic [XLEN-1:0]             exe_mem_data,
  input  logic                        stall,
  input  logic                        flush,
  output logic                        mem_valid,
  output logic [XLEN-1:0]             mem_pc,
  output logic                        mem_we,
  output logic [REG_AW-1:0]           mem_write_reg,
  output logic [XLEN-1:0]             mem_write_data,
  output logic [MOP_W-1:0]            mem_mem_op,
  output logic [XLEN-1:0]             mem_mem_addr,
  output logic [XLEN-1:0]             mem_mem_data,
  input  logic [XLEN-1:0]             lookup_addr,
  output logic                        lookup_hit,
  output logic [XLEN-1:0]             lookup_data,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic [XLEN-1:0]             last_store_addr,
  output logic [XLEN-1:0]             last_store_data
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // History keeps only the word address; byte offset never takes part in matching.
  logic [SB_DEPTH-1:0] sb_valid_q;
  logic [XLEN-3:0]     sb_addr_q [SB_DEPTH];
  logic [XLEN-1:0]     sb_data_q [SB_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q;

  logic is_store;
  logic capture;
  logic unused_lookup_lsb;

  assign is_store          = exe_valid && (exe_mem_op == MOP_W'(`MEM_SW_OP));
  assign capture           = rst && !flush && !stall && is_store;
  assign unused_lookup_lsb = ^lookup_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_valid       <= 1'b0;
      mem_pc          <= '0;
      mem_we          <= 1'b0;
      mem_write_reg   <= '0;
      mem_write_data  <= '0;
      mem_mem_op      <= MOP_W'(`MEM_NOP_OP);
      mem_mem_addr    <= '0;
      mem_mem_data    <= '0;
      sb_valid_q      <= '0;
      wr_ptr_q        <= '0;
      sb_count        <= '0;
      last_store_addr <= '0;
      last_store_data <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_pc         <= '0;
      mem_we         <= 1'b0;
      mem_write_reg  <= '0;
      mem_write_data <= '0;
      mem_mem_op     <= MOP_W'(`MEM_NOP_OP);
      mem_mem_addr   <= '0;
      mem_mem_data   <= '0;
    end else if (!stall) begin
      mem_valid <= exe_valid;
      if (exe_valid) begin
        mem_pc         <= exe_pc;
        mem_we         <= exe_we;
        mem_write_reg  <= exe_write_reg;
        mem_write_data <= exe_write_data;
        mem_mem_op     <= exe_mem_op;
        mem_mem_addr   <= exe_mem_addr;
        mem_mem_data   <= exe_mem_data;
      end else begin
        mem_pc         <= '0;
        mem_we         <= 1'b0;
        mem_write_reg  <= '0;
        mem_write_data <= '0;
        mem_mem_op     <= MOP_W'(`MEM_NOP_OP);
        mem_mem_addr   <= '0;
        mem_mem_data   <= '0;
      end
      if (is_store) begin
        sb_valid_q[wr_ptr_q] <= 1'b1;
        sb_addr_q[wr_ptr_q]  <= exe_mem_addr[XLEN-1:2];
        sb_data_q[wr_ptr_q]  <= exe_mem_data;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
        if (sb_count != CntW'(SB_DEPTH)) sb_count <= sb_count + 1'b1;
        last_store_addr      <= exe_mem_addr;
        last_store_data      <= exe_mem_data;
      end
    end
  end

  // Walk from oldest to newest so later (newer) matches override earlier ones.
  logic [PtrW-1:0] idx;
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    for (int age = SB_DEPTH; age >= 1; age--) begin
      idx = wr_ptr_q - PtrW'(age);
      if (sb_valid_q[idx] && (sb_addr_q[idx] == lookup_addr[XLEN-1:2])) begin
        lookup_hit  = 1'b1;
        lookup_data = sb_data_q[idx];
      end
    end
`ifdef SB_BYPASS_EN
    if (capture && (exe_mem_addr[XLEN-1:2] == lookup_addr[XLEN-1:2])) begin
      lookup_hit  = 1'b1;
      lookup_data = exe_mem_data;
    end
`endif
  end

`ifndef SB_BYPASS_EN
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised EXE→MEM pipeline register for the CPU core. It replaces the single-entry stage register with one that has a valid bit, stall/flush priority and bubble insertion. It also keeps a circular history of the last SB_DEPTH stores, with a word-address lookup port that the MEM/hazard logic uses for store-to-load forwarding. All state updates on the rising edge of clk.

Parameters:
XLEN, 32, datapath/address/PC width
REG_AW, 5, register-index width
MOP_W, 4, memory-op code width; codes come from the shared defines (`MEM_NOP_OP`, `MEM_SW_OP`)
SB_DEPTH, 4, store-history entries; power of 2, ≥2

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets)
exe_valid  in  1  EXE holds a real instruction
exe_pc  in  XLEN  instruction PC
exe_we  in  1  register write enable
exe_write_reg  in  REG_AW  destination register
exe_write_data  in  XLEN  ALU result
exe_mem_op  in  MOP_W  memory op code
exe_mem_addr  in  XLEN  memory address
exe_mem_data  in  XLEN  store data
stall  in  1  hold the stage
flush  in  1  squash the stage (insert a bubble)
mem_valid  out  1  MEM holds a real instruction
mem_pc  out  XLEN  registered exe_pc
mem_we  out  1  registered exe_we
mem_write_reg  out  REG_AW  registered exe_write_reg
mem_write_data  out  XLEN  registered exe_write_data
mem_mem_op  out  MOP_W  registered exe_mem_op
mem_mem_addr  out  XLEN  registered exe_mem_addr
mem_mem_data  out  XLEN  registered exe_mem_data
lookup_addr  in  XLEN  forwarding query address
lookup_hit  out  1  query matches a stored entry
lookup_data  out  XLEN  data of the newest matching entry
sb_count  out  $clog2(SB_DEPTH)+1  number of valid history entries
last_store_addr  out  XLEN  address of the most recent captured store
last_store_data  out  XLEN  data of the most recent captured store

Behaviour:
- Latency: 1 cycle, EXE to MEM outputs.
- Per-edge priority: reset > flush > stall > advance.
- Reset:
  - mem_valid=0, mem_we=0, mem_mem_op=`MEM_NOP_OP`; all other mem_* outputs = 0.
  - All history entries invalid, write pointer = 0, sb_count=0.
  - last_store_addr = last_store_data = 0.
  - Reset mid-stall or mid-flush still fully clears.
- Flush: stage becomes a bubble with the reset values above. History, pointer and last_store_* are unchanged, and the squashed instruction is not recorded.
- Stall (flush=0): every register holds, including history. The EXE instruction is not recorded, because it will be re-presented.
- Advance: all mem_* outputs capture their exe_* counterparts and mem_valid=exe_valid. If exe_valid=0, a bubble is loaded: we=0, op=`MEM_NOP_OP`, other fields 0.
- Store capture happens on advance when exe_valid=1 and exe_mem_op==`MEM_SW_OP`:
  - entry[wr_ptr] ← {valid, exe_mem_addr, exe_mem_data}; wr_ptr ← (wr_ptr+1) mod SB_DEPTH.
  - sb_count increments and saturates at SB_DEPTH.
  - When full, the oldest entry is overwritten.
  - last_store_addr/data ← exe_mem_addr/data.
- Duplicate addresses are appended, not merged.
- Lookup is combinational over registered entries only:
  - Compare lookup_addr[XLEN-1:2] with entry addr[XLEN-1:2] (word match).
  - The newest valid match wins; age is measured backwards from wr_ptr-1.
  - No match: lookup_hit=0, lookup_data=0.
- A store captured at edge N is visible to lookup from edge N onward, not before.
- An empty buffer always reports lookup_hit=0.

Optional Feature:
- Macro: SB_BYPASS_EN.
- Defined: lookup also compares against the incoming EXE store whenever it would be captured this edge (rst=1, flush=0, stall=0, exe_valid=1, op=`MEM_SW_OP`). That match takes priority over all history entries and returns exe_mem_data, combinationally in the same cycle.
- Undefined: lookup sees registered history only.

Test Plan:
- Reset, then hold rst=0 with all inputs toggling → every output 0, mem_mem_op=`MEM_NOP_OP`, sb_count=0, lookup_hit=0 for lookup_addr=0.
- SW addr 0x100 data 0xAA, then lookup 0x102 → lookup_hit=1, lookup_data=0xAA, last_store_addr=0x100, sb_count=1.
- Five SWs (SB_DEPTH=4) to 0x0,0x4,0x8,0xC,0x10 with data 1..5 → sb_count=4; lookup 0x0 misses; lookup 0x10 returns 5.
- SWs to 0x20 with data 7 then data 9 → lookup 0x20 returns 9.
- SW presented with stall=1 for 2 cycles, then stall=0 → outputs hold during the stall; entry recorded once, sb_count=1. SW presented with flush=1 → mem_valid=0, sb_count unchanged.
- With SB_BYPASS_EN: history holds 0x40→3; SW 0x40 data 8 in EXE with stall=0 → lookup 0x40 returns 8 in the same cycle. Without the macro → returns 3 until the next edge.
